// File: rtl/instr_memory.sv
// -----------------------------------------------------------------------------
// instr_memory
//
// Instruction store for a small CPU. A fixed boot table supplies the program
// after reset. A host may replace it with a full DEPTH-word image that is
// streamed in through a valid/ready download port. Once a download completes,
// fetches read the RAM image instead of the boot table. The RAM image stays
// active until the next reset or the next download start.
//
// Ports
//   clk          in   system clock, all state on posedge
//   reset        in   asynchronous, active-high reset
//   count        in   fetch address from the program counter
//   fetch_en     in   fetch request for count this cycle
//   instruction  out  registered fetched word (holds when no fetch)
//   instr_valid  out  instruction carries a fetch result from the previous cycle
//   load_start   in   one-cycle pulse, begin (or restart) a program download
//   load_data    in   download word
//   load_valid   in   load_data valid
//   load_ready   out  download word accepted this cycle (high only in LOAD)
//   load_done    out  one-cycle pulse after the last word is written
//   prog_loaded  out  RAM image is the active fetch source
// -----------------------------------------------------------------------------
module instr_memory #(
    parameter int COUNTER_WIDTH     = 4,
    parameter int INSTRUCTION_WIDTH = 11,
    parameter int DEPTH             = 2**COUNTER_WIDTH,
    // Opcode encodings (upper INSTRUCTION_WIDTH-8 bits of a word)
    parameter logic [INSTRUCTION_WIDTH-9:0] OP_LOADI = (INSTRUCTION_WIDTH-8)'(1),
    parameter logic [INSTRUCTION_WIDTH-9:0] OP_MOVE  = (INSTRUCTION_WIDTH-8)'(2),
    parameter logic [INSTRUCTION_WIDTH-9:0] OP_ADD   = (INSTRUCTION_WIDTH-8)'(3),
    parameter logic [INSTRUCTION_WIDTH-9:0] OP_RESET = (INSTRUCTION_WIDTH-8)'(7)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [COUNTER_WIDTH-1:0]     count,
    input  logic                         fetch_en,
    output logic [INSTRUCTION_WIDTH-1:0] instruction,
    output logic                         instr_valid,
    input  logic                         load_start,
    input  logic [INSTRUCTION_WIDTH-1:0] load_data,
    input  logic                         load_valid,
    output logic                         load_ready,
    output logic                         load_done,
    output logic                         prog_loaded
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [COUNTER_WIDTH-1:0] LAST_PTR = COUNTER_WIDTH'(DEPTH - 1);
    localparam logic [COUNTER_WIDTH:0]   DEPTH_L  = (COUNTER_WIDTH + 1)'(DEPTH);

    // Program RAM, contents are never reset; only read once a full image
    // has been written, so stale contents are never observed.
    logic [INSTRUCTION_WIDTH-1:0] ram [DEPTH];

    state_t                       state_q, state_d;
    logic [COUNTER_WIDTH-1:0]     wptr_q, wptr_d;
    logic                         prog_loaded_q, prog_loaded_d;
    logic                         load_ready_q, load_ready_d;
    logic                         load_done_q, load_done_d;
    logic [INSTRUCTION_WIDTH-1:0] instruction_q, instruction_d;
    logic                         instr_valid_q, instr_valid_d;
    logic                         ram_we;
    logic                         in_range;
    logic [INSTRUCTION_WIDTH-1:0] fetch_word;

    // Fixed boot program
    function automatic logic [INSTRUCTION_WIDTH-1:0] boot_word(
        input logic [COUNTER_WIDTH-1:0] addr
    );
        logic [INSTRUCTION_WIDTH-1:0] w;
        case (int'(addr))
            1:       w = {OP_LOADI, 8'd3};
            2:       w = {OP_MOVE,  8'd0};
            3:       w = {OP_LOADI, 8'd1};
            4:       w = {OP_ADD,   8'd0};
            5:       w = {OP_RESET, 8'd0};
            6:       w = {OP_LOADI, 8'd1};
            7:       w = {OP_ADD,   8'd0};
            8:       w = {OP_RESET, 8'd0};
            default: w = '0;
        endcase
        return w;
    endfunction

    assign in_range = ({1'b0, count} < DEPTH_L);

    always_comb begin
        fetch_word = '0;
        if (in_range) begin
            fetch_word = prog_loaded_q ? ram[count] : boot_word(count);
        end
    end

    // Loader next-state logic
    always_comb begin
        state_d       = state_q;
        wptr_d        = wptr_q;
        prog_loaded_d = prog_loaded_q;
        ram_we        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (load_start) begin
                    state_d       = S_LOAD;
                    wptr_d        = '0;
                    prog_loaded_d = 1'b0;
                end
            end
            S_LOAD: begin
                // A restart wins over a coincident write, which is dropped.
                if (load_start) begin
                    wptr_d = '0;
                end else if (load_valid && load_ready_q) begin
                    ram_we = 1'b1;
                    if (wptr_q == LAST_PTR) begin
                        // Pointer parks on the last slot; address 0 is
                        // never rewritten by the tail of a download.
                        state_d       = S_DONE;
                        prog_loaded_d = 1'b1;
                    end else begin
                        wptr_d = wptr_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (load_start) begin
                    state_d       = S_LOAD;
                    wptr_d        = '0;
                    prog_loaded_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Registered handshake outputs track the state being entered.
        load_ready_d = (state_d == S_LOAD);
        load_done_d  = (state_d == S_DONE);
    end

    // Fetch path: one-cycle latency, blanked while a download is in flight.
    always_comb begin
        instruction_d = instruction_q;
        instr_valid_d = 1'b0;
        if (fetch_en) begin
            if (state_q == S_LOAD || state_q == S_DONE) begin
                instruction_d = '0;
                instr_valid_d = 1'b0;
            end else begin
                instruction_d = fetch_word;
                instr_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            wptr_q        <= '0;
            prog_loaded_q <= 1'b0;
            load_ready_q  <= 1'b0;
            load_done_q   <= 1'b0;
            instruction_q <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wptr_q        <= wptr_d;
            prog_loaded_q <= prog_loaded_d;
            load_ready_q  <= load_ready_d;
            load_done_q   <= load_done_d;
            instruction_q <= instruction_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[wptr_q] <= load_data;
        end
    end

    assign instruction = instruction_q;
    assign instr_valid = instr_valid_q;
    assign load_ready  = load_ready_q;
    assign load_done   = load_done_q;
    assign prog_loaded = prog_loaded_q;

endmodule

// File: doc/instr_memory.md
INSTR_MEMORY -- requirements
Module: instr_memory

Interface
REQ-001 SHALL have parameter COUNTER_WIDTH, default 4, meaning fetch address width.
REQ-002 SHALL have parameter INSTRUCTION_WIDTH, default 11, meaning instruction word width (opcode + 8-bit operand).
REQ-003 SHALL have parameter DEPTH, default 2**COUNTER_WIDTH, meaning number of writable program words.
REQ-004 SHALL have port clk  input  1  system clock, all state rises on posedge; one clock only.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port count  input  COUNTER_WIDTH  fetch address from program counter.
REQ-007 SHALL have port fetch_en  input  1  fetch request for count this cycle.
REQ-008 SHALL have port instruction  output  INSTRUCTION_WIDTH  registered fetched word.
REQ-009 SHALL have port instr_valid  output  1  instruction holds a valid fetch result.
REQ-010 SHALL have port load_start  input  1  one-cycle pulse, begin program download.
REQ-011 SHALL have port load_data  input  INSTRUCTION_WIDTH  download word.
REQ-012 SHALL have port load_valid  input  1  load_data valid.
REQ-013 SHALL have port load_ready  output  1  block accepts a download word this cycle.
REQ-014 SHALL have port load_done  output  1  one-cycle pulse after last word written.
REQ-015 SHALL have port prog_loaded  output  1  RAM image is active instead of boot table.

Function
REQ-016 SHALL contain a DEPTH x INSTRUCTION_WIDTH RAM (no reset of contents) and a fixed boot table: addr1 {LOADI,3}, addr2 {MOVE,0}, addr3 {LOADI,1}, addr4 {ADD,0}, addr5 {RESET,0}, addr6 {LOADI,1}, addr7 {ADD,0}, addr8 {RESET,0}, all other addresses 0; opcodes per parameters.h.
REQ-017 SHALL implement loader FSM states IDLE, LOAD, DONE; reset state IDLE.
REQ-018 IDLE -> LOAD on load_start; write pointer wptr cleared to 0; prog_loaded cleared in same cycle.
REQ-019 In LOAD, load_ready SHALL be 1; on load_valid && load_ready, RAM[wptr] <= load_data, wptr increments by 1.
REQ-020 Write with wptr == DEPTH-1 SHALL move LOAD -> DONE; wptr SHALL not wrap to re-write address 0.
REQ-021 DONE SHALL last exactly one cycle: load_done = 1, prog_loaded set to 1, then -> IDLE.
REQ-022 load_start in LOAD or DONE SHALL restart: wptr = 0, state LOAD, prog_loaded = 0, no load_done pulse; a write coincident with load_start is discarded.
REQ-023 load_valid outside LOAD SHALL be ignored (no write, no pointer change).
REQ-024 Fetch latency SHALL be 1 cycle: fetch_en at edge N -> instruction/instr_valid updated at edge N+1.
REQ-025 Fetch source SHALL be RAM[count] when prog_loaded = 1, else boot table[count].
REQ-026 While state is LOAD or DONE, a fetch SHALL return instruction = 0 and instr_valid = 0.
REQ-027 Without fetch_en, instr_valid SHALL be 0 next cycle and instruction SHALL hold its last value.
REQ-028 Addresses >= DEPTH (when DEPTH < 2**COUNTER_WIDTH) SHALL read 0 with instr_valid = 1.

Reset
REQ-029 Reset SHALL force state IDLE, wptr 0, instruction 0, instr_valid 0, load_ready 0, load_done 0, prog_loaded 0, asynchronously.
REQ-030 Reset mid-download SHALL abandon it; fetches after reset SHALL use the boot table; RAM contents undefined-but-unused until next completed download.

Verification
REQ-031 Reset, fetch_en with count=1 -> next cycle instruction = {LOADI,8'd3}, instr_valid = 1; count=9 -> 0.
REQ-032 load_start, 16 words 0x100+i with load_valid continuous -> load_ready high 16 cycles, load_done pulse one cycle after 16th write, prog_loaded = 1; fetch count=5 -> 0x105.
REQ-033 Download with load_valid toggling every other cycle -> same final image, exactly 16 writes, load_done once.
REQ-034 Fetch during LOAD -> instr_valid = 0, instruction = 0; after DONE fetch count=0 -> downloaded word 0.
REQ-035 load_start after 7 words -> wptr restarts at 0, no load_done until 16 further writes; prog_loaded 0 throughout.
REQ-036 Reset asserted after 10 words of a download -> prog_loaded 0, load_ready 0, fetch count=4 -> {ADD,8'd0}.
